// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, the GF(2^8) helper functions and the
// MixColumns sequencer state encoding.
// Optional feature macro MIXCOL_INV_EN adds the inverse-MixColumns
// multipliers gmul9/gmulB/gmulD/gmulE.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mixcol_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse coefficients are built from the x2, x4 and x8 terms of one
  // xtime chain.
  function automatic logic [7:0] gmul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gmulB(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gmulD(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gmulE(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mixcol_word.sv
// mixcol_word: combinational mixer for one 32-bit AES column.
// Ports:
//   inv - 1 selects inverse MixColumns (only honoured with MIXCOL_INV_EN)
//   a   - input column, byte r at bits [31-8r -: 8]
//   b   - mixed column, same packing
// Optional feature macro: MIXCOL_INV_EN.
module mixcol_word
  import aes_pkg::*;
(
  input  logic      inv,
  input  aes_word_t a,
  output aes_word_t b
);

  logic [7:0] a0, a1, a2, a3;
  aes_word_t  fwd;

  assign a0 = a[31:24];
  assign a1 = a[23:16];
  assign a2 = a[15:8];
  assign a3 = a[7:0];

  assign fwd = {xtime(a0) ^ gmul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

`ifdef MIXCOL_INV_EN
  aes_word_t rev;

  assign rev = {gmulE(a0) ^ gmulB(a1) ^ gmulD(a2) ^ gmul9(a3),
                gmul9(a0) ^ gmulE(a1) ^ gmulB(a2) ^ gmulD(a3),
                gmulD(a0) ^ gmul9(a1) ^ gmulE(a2) ^ gmulB(a3),
                gmulB(a0) ^ gmulD(a1) ^ gmul9(a2) ^ gmulE(a3)};

  assign b = inv ? rev : fwd;
`else
  // Forward-only build: the mode input exists for a uniform interface.
  logic unused_inv;
  assign unused_inv = inv;
  assign b = fwd;
`endif

endmodule

// File: rtl/mixcolumns_seq.sv
// mixcolumns_seq: iterative AES MixColumns, COLS_PER_CYCLE columns per
// clock, valid/ready on both sides.
// Ports:
//   clk_i     - clock, rising edge
//   reset_n_i - asynchronous active-low reset
//   valid_i / ready_o / data_i  - input state handshake (128-bit state)
//   inv_i     - inverse mode, sampled on accept (MIXCOL_INV_EN only)
//   valid_o / ready_i / data_o  - result handshake, data_o held in DONE
// Column c of a state is bits [127-32c -: 32].
// Optional feature macro: MIXCOL_INV_EN.
module mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
`ifdef MIXCOL_INV_EN
  input  logic         inv_i,
`endif
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  localparam int NCYC  = 4 / COLS_PER_CYCLE;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mixcol_state_e    state_p0;
  aes_state_t       work_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             inv_sel;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  aes_word_t        col_in  [COLS_PER_CYCLE];
  aes_word_t        col_out [COLS_PER_CYCLE];
  aes_state_t       work_nxt;

  // Column c lives at bit offset 96-32c, which is {~c, 5'b0} for 2-bit c.
  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_idx[k] = 2'(int'(cnt_p0) * COLS_PER_CYCLE + k);
      col_in[k]  = work_p0[{~col_idx[k], 5'd0} +: 32];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    mixcol_word u_mix (
      .inv (inv_sel),
      .a   (col_in[k]),
      .b   (col_out[k])
    );
  end

  always_comb begin
    work_nxt = work_p0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_nxt[{~col_idx[k], 5'd0} +: 32] = col_out[k];
    end
  end

`ifdef MIXCOL_INV_EN
  logic inv_p0;
  assign inv_sel = inv_p0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inv_p0 <= 1'b0;
    end else if (state_p0 == IDLE && valid_i) begin
      inv_p0 <= inv_i;
    end
  end
`else
  assign inv_sel = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_p0 <= IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      data_o   <= '0;
      cnt_p0   <= '0;
      work_p0  <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (valid_i) begin
            work_p0  <= data_i;
            cnt_p0   <= '0;
            ready_o  <= 1'b0;
            state_p0 <= BUSY;
          end
        end
        BUSY: begin
          work_p0 <= work_nxt;
          cnt_p0  <= cnt_p0 + 1'b1;
          if (cnt_p0 == CNT_W'(NCYC - 1)) begin
            data_o   <= work_nxt;
            valid_o  <= 1'b1;
            state_p0 <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o  <= 1'b0;
            ready_o  <= 1'b1;
            state_p0 <= IDLE;
          end
        end
        default: begin
          state_p0 <= IDLE;
          ready_o  <= 1'b1;
          valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
